// File: rtl/cdb_issue_arbiter_if.sv
// Issue-queue / CDB bundle between the four execution queues and cdb_issue_arbiter.
// Handshake: a queue head is offered with <q>_rdy/<q>_tag; <q>_issue is the same-cycle grant and the queue pops on the closing edge.
interface cdb_issue_arbiter_if #(
    parameter int TAG_W = 6
);
    logic             flush;
    logic             int_rdy;
    logic             ldst_rdy;
    logic             mult_rdy;
    logic             div_rdy;
    logic [TAG_W-1:0] int_tag;
    logic [TAG_W-1:0] ldst_tag;
    logic [TAG_W-1:0] mult_tag;
    logic [TAG_W-1:0] div_tag;
    logic             int_issue;
    logic             ldst_issue;
    logic             mult_issue;
    logic             div_issue;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [1:0]       cdb_src;
    logic             div_busy;
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_issue_cnt;

    modport master (
        output flush, int_rdy, ldst_rdy, mult_rdy, div_rdy,
        output int_tag, ldst_tag, mult_tag, div_tag,
        input  int_issue, ldst_issue, mult_issue, div_issue,
        input  cdb_valid, cdb_tag, cdb_src, div_busy, perf_stall_cnt, perf_issue_cnt
    );

    modport slave (
        input  flush, int_rdy, ldst_rdy, mult_rdy, div_rdy,
        input  int_tag, ldst_tag, mult_tag, div_tag,
        output int_issue, ldst_issue, mult_issue, div_issue,
        output cdb_valid, cdb_tag, cdb_src, div_busy, perf_stall_cnt, perf_issue_cnt
    );
endinterface

// File: rtl/cdb_issue_arbiter.sv
// Round-robin issue arbiter that reserves future CDB slots by unit latency so writebacks never collide.
// Optional perf counters are built only when CDB_ARB_PERF_EN is defined.
module cdb_issue_arbiter #(
    parameter int TAG_W    = 6,
    parameter int INT_LAT  = 1,
    parameter int LDST_LAT = 2,
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    cdb_issue_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(DIV_LAT + 1);

    typedef struct packed {
        logic             v;
        logic [1:0]       src;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t                   slot_q [1:DIV_LAT];
    res_t                   slot_d [1:DIV_LAT];
    res_t                   cdb_q, cdb_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       div_cnt_q, div_cnt_d;

    logic [3:0]             rdy, elig, grant;
    logic [3:0][TAG_W-1:0]  tag_in;
    logic                   div_busy, found;
    logic [1:0]             win, rr_idx;
    int                     win_lat;
    res_t                   new_res;

    assign rdy      = {bus.div_rdy, bus.mult_rdy, bus.ldst_rdy, bus.int_rdy};
    assign tag_in   = {bus.div_tag, bus.mult_tag, bus.ldst_tag, bus.int_tag};
    assign div_busy = (div_cnt_q != '0);

    // A queue may issue only if the CDB slot its latency lands on is still free.
    assign elig[0] = rdy[0] && !slot_q[INT_LAT].v  && !bus.flush;
    assign elig[1] = rdy[1] && !slot_q[LDST_LAT].v && !bus.flush;
    assign elig[2] = rdy[2] && !slot_q[MULT_LAT].v && !bus.flush;
    assign elig[3] = rdy[3] && !slot_q[DIV_LAT].v  && !div_busy && !bus.flush;

    always_comb begin
        found  = 1'b0;
        win    = '0;
        rr_idx = '0;
        for (int k = 0; k < 4; k++) begin
            rr_idx = rr_ptr_q + 2'(k);
            if (!found && elig[rr_idx]) begin
                found = 1'b1;
                win   = rr_idx;
            end
        end
        grant = '0;
        if (found) grant[win] = 1'b1;
        case (win)
            2'd0:    win_lat = INT_LAT;
            2'd1:    win_lat = LDST_LAT;
            2'd2:    win_lat = MULT_LAT;
            default: win_lat = DIV_LAT;
        endcase
        new_res = '{v: found, src: win, tag: tag_in[win]};
    end

    always_comb begin
        for (int i = 1; i < DIV_LAT; i++) slot_d[i] = slot_q[i+1];
        slot_d[DIV_LAT] = '0;
        cdb_d     = slot_q[1];
        rr_ptr_d  = rr_ptr_q;
        div_cnt_d = div_busy ? (div_cnt_q - CNT_W'(1)) : div_cnt_q;
        if (found) begin
            rr_ptr_d = win + 2'd1;
            if (win_lat == 1) cdb_d = new_res;
            // Land in slot[L-1] after the shift, so it reaches the CDB exactly L cycles out.
            for (int i = 1; i < DIV_LAT; i++) begin
                if (win_lat == i + 1) slot_d[i] = new_res;
            end
            if (grant[3]) div_cnt_d = CNT_W'(DIV_LAT - 1);
        end
        if (bus.flush) begin
            for (int i = 1; i <= DIV_LAT; i++) slot_d[i] = '0;
            cdb_d     = '0;
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i <= DIV_LAT; i++) slot_q[i] <= '0;
            cdb_q     <= '0;
            rr_ptr_q  <= '0;
            div_cnt_q <= '0;
        end else begin
            for (int i = 1; i <= DIV_LAT; i++) slot_q[i] <= slot_d[i];
            cdb_q     <= cdb_d;
            rr_ptr_q  <= rr_ptr_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign bus.int_issue  = grant[0];
    assign bus.ldst_issue = grant[1];
    assign bus.mult_issue = grant[2];
    assign bus.div_issue  = grant[3];
    assign bus.cdb_valid  = cdb_q.v;
    assign bus.cdb_tag    = cdb_q.tag;
    assign bus.cdb_src    = cdb_q.src;
    assign bus.div_busy   = div_busy;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, issue_cnt_q, issue_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        issue_cnt_d = issue_cnt_q;
        if ((|rdy) && !found && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (found && (issue_cnt_q != '1))            issue_cnt_d = issue_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_issue_cnt = issue_cnt_q;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_issue_cnt = '0;
`endif
endmodule
